// File: rtl/mash_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mash_pkg
// Brief   : Shared types and limits for the MASH 1-1-1 noise-cancellation path.
// Revision: 1.0 - initial release
// ============================================================================
package mash_pkg;

    localparam int MASH_FRAC_W   = 4;
    localparam int MASH_FRAC_MIN = -3;
    localparam int MASH_FRAC_MAX = 4;

    typedef logic signed [MASH_FRAC_W-1:0] mash_frac_t;

    // Promote a single carry bit to a non-negative fractional term.
    function automatic mash_frac_t bit_to_frac(input logic b);
        return mash_frac_t'({{(MASH_FRAC_W-1){1'b0}}, b});
    endfunction

endpackage
`default_nettype wire

// File: rtl/mash_ncn_if.sv
`default_nettype none
// ============================================================================
// Module  : mash_ncn_if
// Brief   : Carry/integer-word inputs and divide-word outputs of mash_ncn.
// Revision: 1.0 - initial release
// ============================================================================
interface mash_ncn_if
    import mash_pkg::*;
#(
    parameter int P_INT_WIDTH = 8
);
    logic                   i_en;
    logic                   i_clr;
    logic                   i_q1;
    logic                   i_q2;
    logic                   i_q3;
    logic [P_INT_WIDTH-1:0] i_nint;
    mash_frac_t             o_frac;
    logic [P_INT_WIDTH-1:0] o_div;
    logic                   o_sat;
    logic                   o_valid;

    modport master (
        output i_en, i_clr, i_q1, i_q2, i_q3, i_nint,
        input  o_frac, o_div, o_sat, o_valid
    );

    modport slave (
        input  i_en, i_clr, i_q1, i_q2, i_q3, i_nint,
        output o_frac, o_div, o_sat, o_valid
    );
endinterface
`default_nettype wire

// File: rtl/mash_ncn_bit_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : bit_delay_line
// Brief   : Enable/clear-aware single-bit delay of P_DEPTH cycles (0 = wire).
// Revision: 1.0 - initial release
// ============================================================================
module bit_delay_line #(
    parameter int P_DEPTH = 0
) (
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic i_en,
    input  wire logic i_clr,
    input  wire logic i_d,
    output logic      o_q
);

    generate
        if (P_DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = &{1'b0, i_clk, i_rst_n, i_en, i_clr};
            assign o_q      = i_d;
        end else begin : g_shift
            logic [P_DEPTH-1:0] r_sr;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_sr <= '0;
                end else if (i_en) begin
                    if (i_clr) begin
                        r_sr <= '0;
                    end else begin
                        r_sr[0] <= i_d;
                        for (int i = 1; i < P_DEPTH; i++) begin
                            r_sr[i] <= r_sr[i-1];
                        end
                    end
                end
            end

            assign o_q = r_sr[P_DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mash_ncn.sv
`default_nettype none
// ============================================================================
// Module  : mash_ncn
// Brief   : MASH 1-1-1 noise-cancellation network with saturated divide word.
// Revision: 1.0 - initial release
// ============================================================================
module mash_ncn
    import mash_pkg::*;
#(
    parameter int P_INT_WIDTH = 8,
    parameter int P_ALIGN1    = 2,
    parameter int P_ALIGN2    = 1
) (
    input  wire logic  i_clk,
    input  wire logic  i_rst_n,
    mash_ncn_if.slave  bus
);

    localparam int C_FILL_MAX = P_ALIGN1 + 3;
    localparam int C_CNT_W    = $clog2(C_FILL_MAX + 1);
    localparam int C_SUM_W    = P_INT_WIDTH + 2;
    localparam logic [C_CNT_W-1:0] C_FILL_MAX_V = C_FILL_MAX[C_CNT_W-1:0];
    localparam logic signed [C_SUM_W-1:0] C_DIV_MAX = $signed({2'b00, {P_INT_WIDTH{1'b1}}});

    logic w_a1;
    logic w_a2;
    logic w_a3;

    logic r_a2_d1;
    logic r_a3_d1;
    logic r_a3_d2;

    mash_frac_t                r_frac;
    logic [P_INT_WIDTH-1:0]    r_div;
    logic                      r_sat;
    logic [C_CNT_W-1:0]        r_cnt;

    mash_frac_t                w_y;
    logic signed [C_SUM_W-1:0] w_s;
    logic [P_INT_WIDTH-1:0]    w_div;
    logic                      w_sat;

    bit_delay_line #(.P_DEPTH(P_ALIGN1)) u_align1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (bus.i_en),
        .i_clr   (bus.i_clr),
        .i_d     (bus.i_q1),
        .o_q     (w_a1)
    );

    bit_delay_line #(.P_DEPTH(P_ALIGN2)) u_align2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (bus.i_en),
        .i_clr   (bus.i_clr),
        .i_d     (bus.i_q2),
        .o_q     (w_a2)
    );

    assign w_a3 = bus.i_q3;

    // Modulo-16 arithmetic is exact here since y is bounded to -3..+4.
    always_comb begin
        w_y = bit_to_frac(w_a1)
            + bit_to_frac(w_a2)    - bit_to_frac(r_a2_d1)
            + bit_to_frac(w_a3)    - bit_to_frac(r_a3_d1)
            - bit_to_frac(r_a3_d1) + bit_to_frac(r_a3_d2);
    end

    always_comb begin
        w_s   = $signed({2'b00, bus.i_nint})
              + $signed({{(C_SUM_W-MASH_FRAC_W){w_y[MASH_FRAC_W-1]}}, w_y});
        w_div = w_s[P_INT_WIDTH-1:0];
        w_sat = 1'b0;
        if (w_s < 0) begin
            w_div = '0;
            w_sat = 1'b1;
        end else if (w_s > C_DIV_MAX) begin
            w_div = '1;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a2_d1 <= 1'b0;
            r_a3_d1 <= 1'b0;
            r_a3_d2 <= 1'b0;
            r_frac  <= '0;
            r_div   <= '0;
            r_sat   <= 1'b0;
            r_cnt   <= '0;
        end else if (bus.i_en) begin
            if (bus.i_clr) begin
                r_a2_d1 <= 1'b0;
                r_a3_d1 <= 1'b0;
                r_a3_d2 <= 1'b0;
                r_frac  <= '0;
                r_div   <= '0;
                r_sat   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_a2_d1 <= w_a2;
                r_a3_d1 <= w_a3;
                r_a3_d2 <= r_a3_d1;
                r_frac  <= w_y;
                r_div   <= w_div;
                r_sat   <= w_sat;
                if (r_cnt != C_FILL_MAX_V) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.o_frac  = r_frac;
    assign bus.o_div   = r_div;
    assign bus.o_sat   = r_sat;
    assign bus.o_valid = (r_cnt == C_FILL_MAX_V);

endmodule
`default_nettype wire

// File: tb/tb_mash_ncn.sv
`default_nettype none
// ============================================================================
// Module  : tb_mash_ncn
// Brief   : Directed and randomized checks of mash_ncn against a history model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mash_ncn;
    import mash_pkg::*;

    localparam int W    = 8;
    localparam int A1   = 2;
    localparam int A2   = 1;
    localparam int FILL = A1 + 3;
    localparam int DMAX = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mash_ncn_if #(.P_INT_WIDTH(W)) bus ();

    mash_ncn #(.P_INT_WIDTH(W), .P_ALIGN1(A1), .P_ALIGN2(A2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // h*[k] holds the carry sampled k enabled cycles ago (0 before reset/clear).
    int h1[16];
    int h2[16];
    int h3[16];
    int m_frac, m_div, m_sat, m_cnt;

    int sum_frac, sum_q1, n_range_viol;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int frac_now();
        return int'($signed(bus.o_frac));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            h1[k] = 0; h2[k] = 0; h3[k] = 0;
        end
        m_frac = 0; m_div = 0; m_sat = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit en, input bit clr, input bit q1,
                              input bit q2, input bit q3, input int nint);
        int y, s;
        if (!en) return;
        if (clr) begin
            model_reset();
            return;
        end
        for (int k = 15; k > 0; k--) begin
            h1[k] = h1[k-1]; h2[k] = h2[k-1]; h3[k] = h3[k-1];
        end
        h1[0] = q1; h2[0] = q2; h3[0] = q3;
        y = h1[A1] + (h2[A2] - h2[A2+1]) + (h3[0] - 2*h3[1] + h3[2]);
        s = nint + y;
        m_frac = y;
        if (s < 0) begin
            m_div = 0;    m_sat = 1;
        end else if (s > DMAX) begin
            m_div = DMAX; m_sat = 1;
        end else begin
            m_div = s;    m_sat = 0;
        end
        if (m_cnt < FILL) m_cnt++;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_frac"},  frac_now(),        m_frac);
        check({tag, "_div"},   int'(bus.o_div),   m_div);
        check({tag, "_sat"},   int'(bus.o_sat),   m_sat);
        check({tag, "_valid"}, int'(bus.o_valid), (m_cnt == FILL) ? 1 : 0);
    endtask

    task automatic step(input string tag, input bit en, input bit clr, input bit q1,
                        input bit q2, input bit q3, input int nint);
        bus.i_en   = en;
        bus.i_clr  = clr;
        bus.i_q1   = q1;
        bus.i_q2   = q2;
        bus.i_q3   = q3;
        bus.i_nint = nint[W-1:0];
        @(posedge clk);
        model_edge(en, clr, q1, q2, q3, nint);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input int n, input int nint);
        for (int k = 0; k < n; k++) step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nint);
    endtask

    initial begin
        int exp_frac[4];
        int exp_div[4];
        bit en, q1;

        bus.i_en = 1'b0; bus.i_clr = 1'b0;
        bus.i_q1 = 1'b0; bus.i_q2 = 1'b0; bus.i_q3 = 1'b0;
        bus.i_nint = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_frac",  frac_now(),        0);
        check("rst_div",   int'(bus.o_div),   0);
        check("rst_sat",   int'(bus.o_sat),   0);
        check("rst_valid", int'(bus.o_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Constant c1: valid after FILL cycles, then y = +1.
        for (int k = 1; k <= FILL + 3; k++) begin
            step("fill", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20);
            if (k == FILL - 1) check("fill_not_yet", int'(bus.o_valid), 0);
            if (k >= FILL) begin
                check("fill_valid", int'(bus.o_valid), 1);
                check("fill_frac",  frac_now(),        1);
                check("fill_div",   int'(bus.o_div),   21);
                check("fill_sat",   int'(bus.o_sat),   0);
            end
        end

        // Clear then refill.
        step("clr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 20);
        check("clr_frac",  frac_now(),        0);
        check("clr_div",   int'(bus.o_div),   0);
        check("clr_valid", int'(bus.o_valid), 0);
        idle(FILL, 20);
        check("refill_valid", int'(bus.o_valid), 1);

        // c3 pulse: second-difference response.
        exp_frac = '{1, -2, 1, 0};
        exp_div  = '{21, 18, 21, 20};
        step("q3p", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 20);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step("q3p", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20);
            check("q3_pulse_frac", frac_now(),      exp_frac[k]);
            check("q3_pulse_div",  int'(bus.o_div), exp_div[k]);
        end

        // c2 pulse: aligned first difference.
        step("q2p", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20);
        check("q2_pulse_0", frac_now(), 0);
        step("q2p", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20);
        check("q2_pulse_1", frac_now(), 1);
        step("q2p", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20);
        check("q2_pulse_2", frac_now(), -1);
        idle(2, 20);

        // Saturation, low end.
        step("satlo", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step("satlo", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("sat_low_div", int'(bus.o_div), 0);
        check("sat_low_sat", int'(bus.o_sat), 1);
        step("satlo", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("sat_low_release", int'(bus.o_sat), 0);
        idle(2, 20);

        // Saturation, high end and boundary.
        step("sathi", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 255);
        check("sat_high_div", int'(bus.o_div), 255);
        check("sat_high_sat", int'(bus.o_sat), 1);
        idle(3, 20);
        step("satbd", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 254);
        check("sat_bound_div", int'(bus.o_div), 255);
        check("sat_bound_sat", int'(bus.o_sat), 0);
        idle(3, 20);

        // Disabled cycles ignore data and clear alike.
        step("satlo2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        step("satlo2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 10; k++) begin
            step("hold", 1'b0, k[0], 1'b1, 1'b1, 1'b1, 200);
        end
        check("hold_sat",   int'(bus.o_sat),   1);
        check("hold_valid", int'(bus.o_valid), 1);
        check("hold_frac",  frac_now(),        -2);
        step("resume", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20);
        check("resume_frac", frac_now(), 1);

        // Asynchronous reset mid-stream.
        step("pre_rst", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 100);
        step("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 100);
        #2 rst_n = 1'b0;
        #1;
        check("arst_frac",  frac_now(),        0);
        check("arst_div",   int'(bus.o_div),   0);
        check("arst_valid", int'(bus.o_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(FILL - 1, 20);
        check("arst_refill_early", int'(bus.o_valid), 0);
        idle(1, 20);
        check("arst_refill", int'(bus.o_valid), 1);

        // Random stream.
        step("rclr", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        sum_frac = 0; sum_q1 = 0; n_range_viol = 0;
        for (int i = 0; i < 10000; i++) begin
            en = ($urandom_range(0, 9) != 0) && !(i >= 5000 && i < 5010);
            q1 = 1'($urandom_range(0, 1));
            step("rand", en, 1'b0, q1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, DMAX)));
            if (frac_now() < MASH_FRAC_MIN || frac_now() > MASH_FRAC_MAX) n_range_viol++;
            if (en) begin
                sum_frac += frac_now();
                sum_q1   += int'(q1);
            end
        end
        check("rand_frac_range", n_range_viol, 0);
        check("rand_mean_ok",
              ((sum_frac - sum_q1) <= 9 && (sum_q1 - sum_frac) <= 9) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
